cosim_msg_serializer: RTL and testbench
=======================================

Name: cosim_msg_serializer

Overview:
- Sits directly downstream of the cosim endpoint's DataOut channel.
- Accepts one full-width message per handshake and holds it. Emits it to the DUT as a sequence of narrower beats, LSB-first, with a last flag.
- Lets a wide ESI message type drive a narrow DUT interface with proper valid/ready backpressure, which the endpoint itself does not buffer.

Parameters:
- MSG_BITS, 64, width of one message; equals the endpoint's TYPE_SIZE_BITS; must be >= 1.
- WORD_BITS, 8, width of one output beat; must be >= 1.
- Derived (localparam) NUM_BEATS = (MSG_BITS + WORD_BITS - 1) / WORD_BITS.
- Derived (localparam) IDX_BITS = max(1, $clog2(NUM_BEATS)).

Ports:
- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-low
- DataInValid  input  1  message valid, from endpoint DataOutValid
- DataInReady  output  1  block can accept a message, to endpoint DataOutReady
- DataIn  input  MSG_BITS  message payload
- DataOutValid  output  1  beat valid
- DataOutReady  input  1  DUT accepts beat
- DataOut  output  WORD_BITS  beat payload
- DataOutLast  output  1  current beat is the final beat of its message
- DataOutBeatIdx  output  IDX_BITS  index of the current beat within its message
- MsgCount  output  32  number of messages fully emitted; wraps modulo 2^32

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. rstn sampled low at a posedge sets:
  - state IDLE
  - DataOutValid=0, DataOut=0, DataOutLast=0, DataOutBeatIdx=0, MsgCount=0
  - internal shift register cleared
- States:
  - IDLE: no message held.
  - SEND: a message is held and DataOutValid=1.
- DataInReady is combinational:
  - 1 when state==IDLE.
  - 1 when DataOutValid && DataOutReady && DataOutLast.
  - Forced 0 while rstn==0.
- Accept (IDLE): DataInValid && DataInReady at a posedge loads the message:
  - DataIn is zero-extended to NUM_BEATS*WORD_BITS into the shift register.
  - Next cycle: state SEND, DataOutValid=1, DataOutBeatIdx=0, DataOut=DataIn[WORD_BITS-1:0].
  - Latency is 1 cycle from input handshake to first beat valid.
- Beat transfer: DataOutValid && DataOutReady at a posedge completes the beat.
  - Not last: shift register shifts right by WORD_BITS and DataOutBeatIdx increments.
  - Last: MsgCount increments.
- Hold: while DataOutValid=1 and DataOutReady=0, DataOut, DataOutLast and DataOutBeatIdx are stable.
- DataOutLast = (DataOutBeatIdx == NUM_BEATS-1) && DataOutValid.
- Padding: bits of the final beat above MSG_BITS are 0.
- Last beat with no new input (DataInValid=0): go to IDLE; DataOutValid=0 next cycle.
- Last beat with a new message accepted in the same cycle: load the new message; stay in SEND with DataOutValid=1 and DataOutBeatIdx=0. No bubble; full throughput of one message per NUM_BEATS cycles.
- NUM_BEATS==1: every beat has DataOutLast=1; with DataOutReady held 1, one message per cycle is sustained.
- DataInValid with DataInReady=0: ignored; the upstream holds or re-presents the message.
- Reset mid-message: the held message is discarded with no partial completion; MsgCount returns to 0.
- Elaboration: MSG_BITS<1 or WORD_BITS<1 raises $error.

Test Plan:
- MSG_BITS=20, WORD_BITS=8; DataIn=20'hABCDE with valid for 1 cycle; DataOutReady=1 -> beats 8'hDE (idx 0), 8'hBC (idx 1), 8'h0A (idx 2, last=1). Beat 0 is valid 1 cycle after the input handshake. MsgCount=1. DataInReady=0 during beats 0-1.
- Same configuration with DataOutReady=0 for 5 cycles on beat 1 -> DataOut holds 8'hBC with idx 1 for all 5 cycles; the sequence completes unchanged after ready rises.
- Back-to-back: messages 20'h12345 and 20'h6789A offered continuously, DataOutReady=1 -> 6 consecutive valid beats 45,23,01,9A,78,06. No idle cycle between messages; MsgCount=2.
- MSG_BITS=8, WORD_BITS=8; 4 messages 01,02,03,04 streamed with ready=1 -> one beat per cycle, each with last=1; MsgCount=4.
- Assert rstn=0 for 1 cycle during beat 1 of 20'hABCDE -> next cycle DataOutValid=0, MsgCount=0, DataInReady=1. A following message 20'h00001 emits 01,00,00 cleanly with no residue from the discarded message.
- MSG_BITS=20, WORD_BITS=8; DataInValid=1 with DataOutReady=0 while 20'hABCDE is stuck on beat 0 -> DataInReady stays 0 and the second message is not consumed until the first message's last beat handshakes.

Source files
------------

// File: rtl/cosim_msg_serializer.sv
// cosim_msg_serializer
//
// Takes one full-width message from the cosim endpoint's DataOut channel,
// holds it, and replays it to a narrower DUT interface as a series of beats,
// LSB-first, each with valid/ready backpressure. The final beat carries
// DataOutLast. A new message can be accepted in the same cycle that the last
// beat of the current message handshakes, so messages stream with no bubble.
//
// Ports:
//   clk            clock
//   rstn           synchronous, active-low reset
//   DataInValid    message valid from the endpoint
//   DataInReady    block can accept a message (combinational)
//   DataIn         message payload, MSG_BITS wide
//   DataOutValid   beat valid
//   DataOutReady   DUT accepts the current beat
//   DataOut        beat payload, WORD_BITS wide
//   DataOutLast    current beat is the final beat of its message
//   DataOutBeatIdx index of the current beat within its message
//   MsgCount       messages fully emitted, wraps modulo 2^32

module cosim_msg_serializer #(
  parameter int MSG_BITS  = 64,
  parameter int WORD_BITS = 8,
  localparam int NUM_BEATS = (MSG_BITS + WORD_BITS - 1) / WORD_BITS,
  localparam int IDX_BITS  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 DataInValid,
  output logic                 DataInReady,
  input  logic [MSG_BITS-1:0]  DataIn,
  output logic                 DataOutValid,
  input  logic                 DataOutReady,
  output logic [WORD_BITS-1:0] DataOut,
  output logic                 DataOutLast,
  output logic [IDX_BITS-1:0]  DataOutBeatIdx,
  output logic [31:0]          MsgCount
);

  localparam int SHIFT_BITS = NUM_BEATS * WORD_BITS;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_BEATS - 1);

  generate
    if (MSG_BITS < 1) begin : g_bad_msg_bits
      $error("cosim_msg_serializer: MSG_BITS must be >= 1");
    end
    if (WORD_BITS < 1) begin : g_bad_word_bits
      $error("cosim_msg_serializer: WORD_BITS must be >= 1");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                r_state;
  logic [SHIFT_BITS-1:0] r_shift;
  logic [IDX_BITS-1:0]   r_idx;
  logic [31:0]           r_msg_count;

  logic w_valid;
  logic w_last;
  logic w_beat_done;
  logic w_accept;

  assign w_valid     = (r_state == ST_SEND);
  assign w_last      = w_valid && (r_idx == LAST_IDX);
  assign w_beat_done = w_valid && DataOutReady;

  // Ready either when empty or when the held message is finishing this cycle,
  // which is what lets back-to-back messages stream without an idle beat.
  assign DataInReady = rstn && ((r_state == ST_IDLE) || (w_beat_done && w_last));
  assign w_accept    = DataInValid && DataInReady;

  // Outputs come straight from registers, so they are naturally stable while
  // the DUT holds DataOutReady low.
  assign DataOutValid   = w_valid;
  assign DataOut        = r_shift[WORD_BITS-1:0];
  assign DataOutLast    = w_last;
  assign DataOutBeatIdx = r_idx;
  assign MsgCount       = r_msg_count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_idx       <= '0;
      r_msg_count <= '0;
    end else begin
      if (w_beat_done && w_last) begin
        r_msg_count <= r_msg_count + 32'd1;
      end

      if (w_accept) begin
        // Zero-extension leaves the padding bits of the final beat at 0.
        r_state <= ST_SEND;
        r_shift <= SHIFT_BITS'(DataIn);
        r_idx   <= '0;
      end else if (w_beat_done) begin
        if (w_last) begin
          r_state <= ST_IDLE;
        end else begin
          r_shift <= r_shift >> WORD_BITS;
          r_idx   <= r_idx + IDX_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cosim_msg_serializer.sv
module tb_cosim_msg_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: MSG_BITS=20, WORD_BITS=8 -> 3 beats, 2-bit index
  logic        a_rstn;
  logic        a_in_valid;
  logic        a_in_ready;
  logic [19:0] a_in_data;
  logic        a_out_valid;
  logic        a_out_ready;
  logic [7:0]  a_out_data;
  logic        a_out_last;
  logic [1:0]  a_out_idx;
  logic [31:0] a_msg_count;

  // Instance B: MSG_BITS=8, WORD_BITS=8 -> 1 beat, 1-bit index
  logic        b_rstn;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [7:0]  b_in_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [7:0]  b_out_data;
  logic        b_out_last;
  logic [0:0]  b_out_idx;
  logic [31:0] b_msg_count;

  cosim_msg_serializer #(.MSG_BITS(20), .WORD_BITS(8)) u_dut_a (
    .clk            (clk),
    .rstn           (a_rstn),
    .DataInValid    (a_in_valid),
    .DataInReady    (a_in_ready),
    .DataIn         (a_in_data),
    .DataOutValid   (a_out_valid),
    .DataOutReady   (a_out_ready),
    .DataOut        (a_out_data),
    .DataOutLast    (a_out_last),
    .DataOutBeatIdx (a_out_idx),
    .MsgCount       (a_msg_count)
  );

  cosim_msg_serializer #(.MSG_BITS(8), .WORD_BITS(8)) u_dut_b (
    .clk            (clk),
    .rstn           (b_rstn),
    .DataInValid    (b_in_valid),
    .DataInReady    (b_in_ready),
    .DataIn         (b_in_data),
    .DataOutValid   (b_out_valid),
    .DataOutReady   (b_out_ready),
    .DataOut        (b_out_data),
    .DataOutLast    (b_out_last),
    .DataOutBeatIdx (b_out_idx),
    .MsgCount       (b_msg_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here and
  // outputs are sampled one time unit later, well away from any edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_beat(input string tag, input logic [7:0] data,
                              input logic [1:0] idx, input logic last);
    #1;
    check({tag, ".valid"}, 64'(a_out_valid), 64'd1);
    check({tag, ".data"},  64'(a_out_data),  64'(data));
    check({tag, ".idx"},   64'(a_out_idx),   64'(idx));
    check({tag, ".last"},  64'(a_out_last),  64'(last));
    $display("beat %s data=%02h idx=%0d last=%0d", tag, a_out_data, a_out_idx, a_out_last);
  endtask

  initial begin
    a_rstn = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_rstn = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    step();
    step();

    // Reset state
    #1;
    check("rst.valid",    64'(a_out_valid), 64'd0);
    check("rst.data",     64'(a_out_data),  64'd0);
    check("rst.idx",      64'(a_out_idx),   64'd0);
    check("rst.last",     64'(a_out_last),  64'd0);
    check("rst.count",    64'(a_msg_count), 64'd0);
    check("rst.in_ready", 64'(a_in_ready),  64'd0);
    check("rst_b.valid",  64'(b_out_valid), 64'd0);
    a_rstn = 1'b1;
    b_rstn = 1'b1;
    #1;
    check("idle.in_ready", 64'(a_in_ready), 64'd1);
    $display("reset done");

    // T1: single message 20'hABCDE, ready held high
    a_in_valid = 1'b1; a_in_data = 20'hABCDE; a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    check_a_beat("t1.b0", 8'hDE, 2'd0, 1'b0);
    check("t1.b0.in_ready", 64'(a_in_ready), 64'd0);
    step();
    check_a_beat("t1.b1", 8'hBC, 2'd1, 1'b0);
    check("t1.b1.in_ready", 64'(a_in_ready), 64'd0);
    step();
    check_a_beat("t1.b2", 8'h0A, 2'd2, 1'b1);
    check("t1.b2.in_ready", 64'(a_in_ready), 64'd1);
    step();
    #1;
    check("t1.end.valid", 64'(a_out_valid), 64'd0);
    check("t1.end.count", 64'(a_msg_count), 64'd1);

    // T2: stall 5 cycles on beat 1
    a_in_valid = 1'b1; a_in_data = 20'hABCDE; a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    check_a_beat("t2.b0", 8'hDE, 2'd0, 1'b0);
    step();
    a_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_a_beat($sformatf("t2.hold%0d", i), 8'hBC, 2'd1, 1'b0);
      step();
    end
    a_out_ready = 1'b1;
    check_a_beat("t2.b1", 8'hBC, 2'd1, 1'b0);
    step();
    check_a_beat("t2.b2", 8'h0A, 2'd2, 1'b1);
    step();
    #1;
    check("t2.end.valid", 64'(a_out_valid), 64'd0);
    check("t2.end.count", 64'(a_msg_count), 64'd2);

    // T3: back-to-back 20'h12345 then 20'h6789A, no bubble
    a_in_valid = 1'b1; a_in_data = 20'h12345;
    step();
    a_in_data = 20'h6789A;
    check_a_beat("t3.m0b0", 8'h45, 2'd0, 1'b0);
    check("t3.m0b0.in_ready", 64'(a_in_ready), 64'd0);
    step();
    check_a_beat("t3.m0b1", 8'h23, 2'd1, 1'b0);
    step();
    check_a_beat("t3.m0b2", 8'h01, 2'd2, 1'b1);
    check("t3.m0b2.in_ready", 64'(a_in_ready), 64'd1);
    step();
    a_in_valid = 1'b0;
    check_a_beat("t3.m1b0", 8'h9A, 2'd0, 1'b0);
    step();
    check_a_beat("t3.m1b1", 8'h78, 2'd1, 1'b0);
    step();
    check_a_beat("t3.m1b2", 8'h06, 2'd2, 1'b1);
    step();
    #1;
    check("t3.end.valid", 64'(a_out_valid), 64'd0);
    check("t3.end.count", 64'(a_msg_count), 64'd4);

    // T4: reset during beat 1, then a clean message
    a_in_valid = 1'b1; a_in_data = 20'hABCDE;
    step();
    a_in_valid = 1'b0;
    check_a_beat("t4.b0", 8'hDE, 2'd0, 1'b0);
    step();
    check_a_beat("t4.b1", 8'hBC, 2'd1, 1'b0);
    a_rstn = 1'b0;
    step();
    a_rstn = 1'b1;
    #1;
    check("t4.rst.valid",    64'(a_out_valid), 64'd0);
    check("t4.rst.count",    64'(a_msg_count), 64'd0);
    check("t4.rst.in_ready", 64'(a_in_ready),  64'd1);
    check("t4.rst.data",     64'(a_out_data),  64'd0);
    $display("mid-message reset applied");
    a_in_valid = 1'b1; a_in_data = 20'h00001;
    step();
    a_in_valid = 1'b0;
    check_a_beat("t4.n0", 8'h01, 2'd0, 1'b0);
    step();
    check_a_beat("t4.n1", 8'h00, 2'd1, 1'b0);
    step();
    check_a_beat("t4.n2", 8'h00, 2'd2, 1'b1);
    step();
    #1;
    check("t4.end.valid", 64'(a_out_valid), 64'd0);
    check("t4.end.count", 64'(a_msg_count), 64'd1);

    // T5: second message held off while the first is stalled on beat 0
    a_in_valid = 1'b1; a_in_data = 20'hABCDE; a_out_ready = 1'b0;
    step();
    a_in_data = 20'h12345;
    for (int i = 0; i < 4; i++) begin
      check_a_beat($sformatf("t5.stall%0d", i), 8'hDE, 2'd0, 1'b0);
      check($sformatf("t5.stall%0d.in_ready", i), 64'(a_in_ready), 64'd0);
      step();
    end
    a_out_ready = 1'b1;
    check_a_beat("t5.b0", 8'hDE, 2'd0, 1'b0);
    step();
    check_a_beat("t5.b1", 8'hBC, 2'd1, 1'b0);
    check("t5.b1.in_ready", 64'(a_in_ready), 64'd0);
    step();
    check_a_beat("t5.b2", 8'h0A, 2'd2, 1'b1);
    step();
    a_in_valid = 1'b0;
    check_a_beat("t5.m1b0", 8'h45, 2'd0, 1'b0);
    step();
    check_a_beat("t5.m1b1", 8'h23, 2'd1, 1'b0);
    step();
    check_a_beat("t5.m1b2", 8'h01, 2'd2, 1'b1);
    step();
    #1;
    check("t5.end.valid", 64'(a_out_valid), 64'd0);
    check("t5.end.count", 64'(a_msg_count), 64'd3);

    // T6: single-beat configuration streams one message per cycle
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_data   = 8'h01;
    for (int i = 1; i <= 4; i++) begin
      step();
      b_in_data = 8'(i + 1);
      if (i == 4) b_in_valid = 1'b0;
      #1;
      check($sformatf("t6.m%0d.valid", i),    64'(b_out_valid), 64'd1);
      check($sformatf("t6.m%0d.data", i),     64'(b_out_data),  64'(i));
      check($sformatf("t6.m%0d.last", i),     64'(b_out_last),  64'd1);
      check($sformatf("t6.m%0d.idx", i),      64'(b_out_idx),   64'd0);
      check($sformatf("t6.m%0d.in_ready", i), 64'(b_in_ready),  64'd1);
      $display("beat t6.m%0d data=%02h last=%0d", i, b_out_data, b_out_last);
    end
    step();
    #1;
    check("t6.end.valid", 64'(b_out_valid), 64'd0);
    check("t6.end.count", 64'(b_msg_count), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
